// File: rtl/debounce_oneshot.sv
// Push-button conditioner: 2-flop sync, stable-time debounce FSM,
// and single-cycle press/release pulses for the counter enable.
module debounce_oneshot #(
   parameter int unsigned STABLE_TICKS = 1_000_000,
   parameter int unsigned CNT_W        = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_db,
   output logic ped,
   output logic ned
);

   typedef enum logic [1:0] {
      S_LOW,
      S_WAIT_HI,
      S_HIGH,
      S_WAIT_LO
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

   logic             sync1_q;
   logic             sync2_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btn_db_q;
   logic             ped_q;
   logic             ned_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Pulses default low; only the accepting transitions raise them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_LOW;
         cnt_q    <= '0;
         btn_db_q <= 1'b0;
         ped_q    <= 1'b0;
         ned_q    <= 1'b0;
      end else begin
         ped_q <= 1'b0;
         ned_q <= 1'b0;
         unique case (state_q)
            S_LOW: begin
               if (sync2_q) begin
                  state_q <= S_WAIT_HI;
                  cnt_q   <= '0;
               end
            end
            S_WAIT_HI: begin
               if (!sync2_q) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == LAST) begin
                  state_q  <= S_HIGH;
                  cnt_q    <= '0;
                  btn_db_q <= 1'b1;
                  ped_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_HIGH: begin
               if (!sync2_q) begin
                  state_q <= S_WAIT_LO;
                  cnt_q   <= '0;
               end
            end
            S_WAIT_LO: begin
               if (sync2_q) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == LAST) begin
                  state_q  <= S_LOW;
                  cnt_q    <= '0;
                  btn_db_q <= 1'b0;
                  ned_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= S_LOW;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_db = btn_db_q;
   assign ped    = ped_q;
   assign ned    = ned_q;

endmodule
